// File: rtl/uart_clock_mc.sv
// uart_clock_mc - multi-channel programmable sampling-clock generator.
//
// Each channel divides i_clk by an integer divisor N = max(active_int, 1).
// When the fractional feature is built, it also adds a fractional part.
// Each channel produces:
//   - a one-cycle sampling tick at the end of every period;
//   - a square clock that toggles on every tick.
//
// A divisor write lands in a per-channel shadow register. The shadow is
// copied to the active register only at an apply point, so a period is
// never cut short. The apply points are:
//   - the edge that ends a period;
//   - any edge while the channel is disabled;
//   - a resync edge.
//
// Optional feature macro: UART_CLOCK_MC_FRAC_EN
//   defined   : fractional accumulator present; a period lasts N+c cycles,
//               where c is the carry out of acc + active_frac.
//   undefined : no accumulator and no frac registers; i_div_frac is ignored;
//               every period is exactly N cycles.
//
// Ports:
//   i_clk       system clock (the only clock)
//   i_reset_n   asynchronous active-low reset
//   i_enable    per-channel run enable
//   i_resync    per-channel one-cycle phase restart
//   i_div_wr    one-cycle divisor write strobe
//   i_div_sel   channel targeted by the write (out-of-range values ignored)
//   i_div_int   integer divisor
//   i_div_frac  fractional divisor, in units of 1/2^FRAC_W cycle
//   o_pending   written divisor not yet applied
//   o_tick      one-cycle sampling pulse
//   o_clk       divided clock
module uart_clock_mc #(
  parameter  int CHANNELS  = 2,
  parameter  int DIV_W     = 32,
  parameter  int FRAC_W    = 4,
  parameter  int RESET_DIV = 16,
  localparam int SEL_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic [CHANNELS-1:0] i_enable,
  input  logic [CHANNELS-1:0] i_resync,
  input  logic                i_div_wr,
  input  logic [SEL_W-1:0]    i_div_sel,
  input  logic [DIV_W-1:0]    i_div_int,
  input  logic [FRAC_W-1:0]   i_div_frac,
  output logic [CHANNELS-1:0] o_pending,
  output logic [CHANNELS-1:0] o_tick,
  output logic [CHANNELS-1:0] o_clk
);

`ifndef UART_CLOCK_MC_FRAC_EN
  // Without the fractional feature the frac input has no destination.
  logic w_unused_frac;
  assign w_unused_frac = ^i_div_frac;
`endif

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [DIV_W-1:0] r_sh_int;
    logic [DIV_W-1:0] r_act_int;
    // One bit wider than the divisor so that N + carry - 1 always fits.
    logic [DIV_W:0]   r_cnt;
    logic             r_pend;
    logic             r_tick;
    logic             r_oclk;

    logic             w_wr_hit;
    logic [DIV_W:0]   w_n;
    logic             w_carry;
    logic [DIV_W:0]   w_last;
    logic             w_end;
    logic             w_restart;
    logic             w_apply;

    // An out-of-range i_div_sel can never equal a valid channel index.
    assign w_wr_hit = i_div_wr && (i_div_sel == SEL_W'(gi));
    assign w_n      = (r_act_int == '0) ? (DIV_W+1)'(1) : {1'b0, r_act_int};

`ifdef UART_CLOCK_MC_FRAC_EN
    logic [FRAC_W-1:0] r_sh_frac;
    logic [FRAC_W-1:0] r_act_frac;
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_acc_sum;

    assign w_acc_sum = {1'b0, r_acc} + {1'b0, r_act_frac};
    assign w_carry   = w_acc_sum[FRAC_W];

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_sh_frac  <= '0;
        r_act_frac <= '0;
        r_acc      <= '0;
      end else begin
        if (w_restart) begin
          r_acc <= '0;
        end else if (w_end) begin
          r_acc <= w_acc_sum[FRAC_W-1:0];
        end
        if (w_apply) begin
          r_act_frac <= r_sh_frac;
        end
        if (w_wr_hit) begin
          r_sh_frac <= i_div_frac;
        end
      end
    end
`else
    assign w_carry = 1'b0;
`endif

    assign w_last    = w_n + (DIV_W+1)'(w_carry) - (DIV_W+1)'(1);
    assign w_end     = (r_cnt == w_last);
    // Disable and resync both restart the phase.
    // Resync therefore wins over a coincident period end.
    assign w_restart = !i_enable[gi] || i_resync[gi];
    assign w_apply   = w_restart || w_end;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
        r_sh_int  <= DIV_W'(RESET_DIV);
        r_act_int <= DIV_W'(RESET_DIV);
        r_cnt     <= '0;
        r_pend    <= 1'b0;
        r_tick    <= 1'b0;
        r_oclk    <= 1'b0;
      end else begin
        if (w_restart) begin
          r_cnt  <= '0;
          r_tick <= 1'b0;
          r_oclk <= 1'b0;
        end else if (w_end) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_oclk <= ~r_oclk;
        end else begin
          r_cnt  <= r_cnt + (DIV_W+1)'(1);
          r_tick <= 1'b0;
        end
        // The apply consumes the old shadow.
        // A write on the same edge refills the shadow and keeps pending set.
        if (w_apply) begin
          r_act_int <= r_sh_int;
          r_pend    <= 1'b0;
        end
        if (w_wr_hit) begin
          r_sh_int <= i_div_int;
          r_pend   <= 1'b1;
        end
      end
    end

    assign o_pending[gi] = r_pend;
    assign o_tick[gi]    = r_tick;
    assign o_clk[gi]     = r_oclk;
  end

endmodule

// File: tb/tb_uart_clock_mc.sv
// Testbench for uart_clock_mc.
// It covers:
//   - reset values;
//   - a table of hand-derived vectors;
//   - hand-written multi-cycle corner sequences;
//   - randomized traffic checked against a behavioural model.
module tb_uart_clock_mc;
  localparam int CH = 3;
  localparam int DW = 32;
  localparam int FW = 4;
  localparam int RD = 16;
  localparam int SW = 2;
`ifdef UART_CLOCK_MC_FRAC_EN
  localparam bit FRAC_ON = 1'b1;
`else
  localparam bit FRAC_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] en;
  logic [CH-1:0] rs;
  logic          wr;
  logic [SW-1:0] sel;
  logic [DW-1:0] dint;
  logic [FW-1:0] dfrac;
  logic [CH-1:0] pend;
  logic [CH-1:0] tick;
  logic [CH-1:0] oclk;

  uart_clock_mc #(
    .CHANNELS (CH),
    .DIV_W    (DW),
    .FRAC_W   (FW),
    .RESET_DIV(RD)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .i_enable  (en),
    .i_resync  (rs),
    .i_div_wr  (wr),
    .i_div_sel (sel),
    .i_div_int (dint),
    .i_div_frac(dfrac),
    .o_pending (pend),
    .o_tick    (tick),
    .o_clk     (oclk)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit use_model = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Behavioural model: a period ends once the elapsed cycle count reaches
  // N + c.
  longint m_pos[CH];
  longint m_acc[CH];
  longint m_sh_int[CH];
  longint m_act_int[CH];
  longint m_sh_frac[CH];
  longint m_act_frac[CH];
  bit     m_tick[CH];
  bit     m_clk[CH];
  bit     m_pend[CH];

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_acc[c] = 0; m_tick[c] = 0; m_clk[c] = 0; m_pend[c] = 0;
      m_sh_int[c] = RD; m_act_int[c] = RD; m_sh_frac[c] = 0; m_act_frac[c] = 0;
    end
  endfunction

  function automatic void model_step();
    for (int c = 0; c < CH; c++) begin
      bit     apply;
      longint n;
      longint carry;
      apply = 1'b0;
      if (!en[c] || rs[c]) begin
        m_pos[c] = 0; m_acc[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
        apply = 1'b1;
      end else begin
        n = (m_act_int[c] == 0) ? 64'd1 : m_act_int[c];
        carry = (FRAC_ON && (m_acc[c] + m_act_frac[c] >= (64'd1 << FW))) ? 64'd1 : 64'd0;
        if (m_pos[c] + 1 == n + carry) begin
          m_tick[c] = 1; m_pos[c] = 0; m_clk[c] = !m_clk[c];
          m_acc[c] = (m_acc[c] + m_act_frac[c]) % (64'd1 << FW);
          apply = 1'b1;
        end else begin
          m_pos[c] = m_pos[c] + 1; m_tick[c] = 0;
        end
      end
      if (apply) begin
        m_act_int[c] = m_sh_int[c]; m_act_frac[c] = m_sh_frac[c]; m_pend[c] = 0;
      end
      if (wr && (int'(sel) == c)) begin
        m_sh_int[c] = longint'(dint); m_sh_frac[c] = longint'(dfrac); m_pend[c] = 1;
      end
    end
  endfunction

  // One clock edge: advance the model with the inputs seen at the edge.
  // Then sample the DUT 1 time unit later.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step();
    #1;
    if (use_model) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("model ch%0d tick", c), 32'(tick[c]), 32'(m_tick[c]));
        chk($sformatf("model ch%0d clk", c), 32'(oclk[c]), 32'(m_clk[c]));
        chk($sformatf("model ch%0d pending", c), 32'(pend[c]), 32'(m_pend[c]));
      end
    end
  endtask

  task automatic idle_inputs();
    en = '0; rs = '0; wr = 1'b0; sel = '0; dint = '0; dfrac = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [CH-1:0] en;
    logic [CH-1:0] rs;
    logic          wr;
    logic [SW-1:0] sel;
    logic [DW-1:0] di;
    logic          e_tick;
    logic          e_clk;
    logic [CH-1:0] e_pend;
  } vec_t;

  function automatic vec_t mk(input logic [CH-1:0] e, input logic [CH-1:0] r, input logic w,
                              input logic [SW-1:0] s, input logic [DW-1:0] d,
                              input logic et, input logic ec, input logic [CH-1:0] ep);
    vec_t v;
    v.en = e; v.rs = r; v.wr = w; v.sel = s; v.di = d;
    v.e_tick = et; v.e_clk = ec; v.e_pend = ep;
    return v;
  endfunction

  vec_t tbl[12];

  initial begin
    int tick_cnt;
    int first_tick;
    int last_tick;
    int second_tick;

    rst_n = 1'b0;
    idle_inputs();
    #12;
    chk("reset pending", 32'(pend), 32'(0));
    chk("reset tick", 32'(tick), 32'(0));
    chk("reset clk", 32'(oclk), 32'(0));
    cycle();
    rst_n = 1'b1;

    // Table of vectors for ch0. Each row covers one edge.
    tbl[0]  = mk(3'b000, 3'b000, 1'b1, 2'd0, 32'd2, 1'b0, 1'b0, 3'b001); // write on apply edge keeps pending
    tbl[1]  = mk(3'b000, 3'b000, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 3'b000); // disabled: shadow applied
    tbl[2]  = mk(3'b001, 3'b000, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 3'b000);
    tbl[3]  = mk(3'b001, 3'b000, 1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 3'b000); // N=2 tick
    tbl[4]  = mk(3'b001, 3'b000, 1'b1, 2'd0, 32'd0, 1'b0, 1'b1, 3'b001); // write int=0
    tbl[5]  = mk(3'b001, 3'b000, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 3'b000); // applied at period end
    tbl[6]  = mk(3'b001, 3'b000, 1'b0, 2'd0, 32'd0, 1'b1, 1'b1, 3'b000); // period 1
    tbl[7]  = mk(3'b001, 3'b000, 1'b0, 2'd0, 32'd0, 1'b1, 1'b0, 3'b000);
    tbl[8]  = mk(3'b001, 3'b000, 1'b1, 2'd3, 32'd9, 1'b1, 1'b1, 3'b000); // sel out of range ignored
    tbl[9]  = mk(3'b001, 3'b001, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 3'b000); // resync beats period end
    tbl[10] = mk(3'b001, 3'b000, 1'b1, 2'd1, 32'd7, 1'b1, 1'b1, 3'b010); // write to disabled ch1
    tbl[11] = mk(3'b000, 3'b000, 1'b0, 2'd0, 32'd0, 1'b0, 1'b0, 3'b000);
    for (int i = 0; i < 12; i++) begin
      en = tbl[i].en; rs = tbl[i].rs; wr = tbl[i].wr; sel = tbl[i].sel;
      dint = tbl[i].di; dfrac = '0;
      cycle();
      $display("vec %0d: tick0=%0b clk0=%0b pend=%b", i, tick[0], oclk[0], pend);
      chk($sformatf("vec%0d tick0", i), 32'(tick[0]), 32'(tbl[i].e_tick));
      chk($sformatf("vec%0d clk0", i), 32'(oclk[0]), 32'(tbl[i].e_clk));
      chk($sformatf("vec%0d pending", i), 32'(pend), 32'(tbl[i].e_pend));
    end

    // RESET_DIV cadence on ch0; ch1 stays silent.
    do_reset();
    en = 3'b001;
    for (int e = 1; e <= 48; e++) begin
      cycle();
      chk($sformatf("rstdiv e%0d tick0", e), 32'(tick[0]), 32'(e % 16 == 0));
      chk($sformatf("rstdiv e%0d clk0", e), 32'(oclk[0]), 32'((e / 16) % 2));
      chk($sformatf("rstdiv e%0d tick1", e), 32'(tick[1]), 32'(0));
    end
    $display("txn: reset-divisor cadence done");

    // Mid-period write at cnt=3: held pending until the edge-16 tick.
    do_reset();
    en = 3'b001;
    for (int e = 1; e <= 31; e++) begin
      if (e == 4) begin wr = 1'b1; sel = 2'd0; dint = 32'd5; dfrac = '0; end
      cycle();
      wr = 1'b0;
      chk($sformatf("midwr e%0d tick0", e), 32'(tick[0]),
          32'(e == 16 || e == 21 || e == 26 || e == 31));
      chk($sformatf("midwr e%0d pending0", e), 32'(pend[0]), 32'(e >= 4 && e <= 15));
    end
    $display("txn: mid-period write done");

    // Resync on ch1: once mid-period, once on a period-end edge.
    do_reset();
    en = 3'b010;
    for (int e = 1; e <= 56; e++) begin
      rs = (e == 8 || e == 40) ? 3'b010 : 3'b000;
      cycle();
      chk($sformatf("resync e%0d tick1", e), 32'(tick[1]), 32'(e == 24 || e == 56));
      chk($sformatf("resync e%0d clk1", e), 32'(oclk[1]), 32'((e >= 24 && e < 40) || e >= 56));
    end
    rs = '0;
    $display("txn: resync sequence done");

    // Fractional divisor 10 + 8/16 over 20 ticks.
    do_reset();
    wr = 1'b1; sel = 2'd0; dint = 32'd10; dfrac = 4'd8;
    cycle();
    wr = 1'b0;
    cycle();
    en = 3'b001;
    tick_cnt = 0; first_tick = 0; second_tick = 0; last_tick = 0;
    for (int e = 1; e <= 400 && tick_cnt < 20; e++) begin
      cycle();
      if (tick[0]) begin
        tick_cnt++;
        if (tick_cnt == 1) first_tick = e;
        if (tick_cnt == 2) second_tick = e;
        last_tick = e;
      end
    end
    $display("txn: frac 10+8/16 ticks=%0d span=%0d", tick_cnt, last_tick);
    chk("frac tick count", 32'(tick_cnt), 32'(20));
    chk("frac first period", 32'(first_tick), 32'(10));
    chk("frac second period", 32'(second_tick - first_tick), FRAC_ON ? 32'd11 : 32'd10);
    chk("frac 20-tick span", 32'(last_tick), FRAC_ON ? 32'd210 : 32'd200);

    // Asynchronous reset with a pending write and o_clk high.
    do_reset();
    en = 3'b001;
    for (int e = 1; e <= 20; e++) cycle();
    wr = 1'b1; sel = 2'd0; dint = 32'd3; dfrac = '0;
    cycle();
    wr = 1'b0;
    chk("pre-reset clk0", 32'(oclk[0]), 32'(1));
    chk("pre-reset pending0", 32'(pend[0]), 32'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset pending", 32'(pend), 32'(0));
    chk("async reset tick", 32'(tick), 32'(0));
    chk("async reset clk", 32'(oclk), 32'(0));
    cycle();
    rst_n = 1'b1;
    en = 3'b001;
    for (int e = 1; e <= 16; e++) begin
      cycle();
      chk($sformatf("post-reset e%0d tick0", e), 32'(tick[0]), 32'(e == 16));
    end
    $display("txn: async reset sequence done");

    // Randomized traffic against the model.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 500; i++) begin
      for (int c = 0; c < CH; c++) begin
        en[c] = ($urandom_range(0, 15) != 0);
        rs[c] = ($urandom_range(0, 19) == 0);
      end
      wr = ($urandom_range(0, 5) == 0);
      sel = SW'($urandom_range(0, 3));
      dint = ($urandom_range(0, 7) == 0) ? 32'd16 : DW'($urandom_range(0, 6));
      dfrac = FW'($urandom_range(0, 15));
      if (wr) $display("txn rnd %0d: write sel=%0d int=%0d frac=%0d", i, sel, dint, dfrac);
      cycle();
    end
    use_model = 1'b0;
    idle_inputs();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
